rx_ptp_slot_sched: RTL

Receive-side slot scheduler for the PTP frame capture path. It watches the 64-bit XGMII receive stream and assigns each frame to one of NUM_SLOTS fixed-size slots in an external frame RAM, generating the RAM write strobes itself. It then queues completed frames as {slot, length} descriptors for the CPU-side reader and recycles each slot once software releases it. Slots are reused only when software releases them, so back-to-back PTP frames are not overwritten before they are read.

---
 rtl/rx_ptp_slot_sched.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_ptp_slot_sched.sv
// Receive-side PTP frame slot scheduler: XGMII frames into fixed RAM slots, descriptor queue, slot recycling.
// Optional RX_SCHED_FCS_STRIP_EN: reported length (and runt check) excludes the 4-byte FCS.
module rx_ptp_slot_sched #(
  parameter int          NUM_SLOTS  = 4,
  parameter int          SLOT_WORDS = 64,
  parameter logic [7:0]  START_CHAR = 8'hFB,
  parameter logic [7:0]  TERM_CHAR  = 8'hFD,
  localparam int         SW         = $clog2(NUM_SLOTS),
  localparam int         IW         = $clog2(SLOT_WORDS),
  localparam int         AW         = SW + IW,
  localparam int         LW         = $clog2(SLOT_WORDS * 8) + 1
) (
  input  logic          rx_clk,
  input  logic          rx_rst_n,
  input  logic [63:0]   xge_rxd_i,
  input  logic [7:0]    xge_rxc_i,
  output logic          buf_wr_en_o,
  output logic [AW-1:0] buf_wr_addr_o,
  output logic [63:0]   buf_wr_data_o,
  output logic          rdy_valid_o,
  output logic [SW-1:0] rdy_slot_o,
  output logic [LW-1:0] rdy_len_o,
  input  logic          rdy_pop_i,
  input  logic          rel_i,
  input  logic [SW-1:0] rel_slot_i,
  output logic          irq_o,
  output logic [15:0]   drop_cnt_o
);

`ifdef RX_SCHED_FCS_STRIP_EN
  localparam logic [LW-1:0] FCS_BYTES = LW'(4);
`else
  localparam logic [LW-1:0] FCS_BYTES = LW'(0);
`endif
  // Runt threshold is on the reported length, so it moves with the FCS strip.
  localparam logic [LW-1:0] RUNT_MIN = LW'(64) + FCS_BYTES;
  localparam logic [IW:0]   IDX_FULL = (IW+1)'(SLOT_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, DROP} fsm_t;
  typedef enum logic [1:0] {S_FREE, S_FILL, S_READY, S_HELD} slot_t;

  logic [63:0]   rxd_q;
  logic [7:0]    rxc_q;
  fsm_t          st_q, st_d;
  slot_t         slot_st_q [NUM_SLOTS];
  slot_t         slot_st_d [NUM_SLOTS];
  logic [SW-1:0] cur_q, cur_d;
  logic [IW:0]   idx_q, idx_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [63:0]   wr_data_q, wr_data_d;
  logic          irq_q;
  logic [15:0]   drop_q;

  logic [SW-1:0] fifo_slot_q [NUM_SLOTS];
  logic [LW-1:0] fifo_len_q  [NUM_SLOTS];
  logic [SW-1:0] wr_ptr_q, rd_ptr_q;
  logic [SW:0]   cnt_q;

  logic          w_data, w_start, w_term, w_any_term, seen_ctl;
  logic [2:0]    term_k;
  logic [LW-1:0] len_full, push_len;
  logic          push, pop_ok, drop_inc, alloc_req, alloc_ok;
  logic [SW-1:0] alloc_slot;

  // Terminate counts only when it is the first control lane of the word.
  always_comb begin
    w_data     = (rxc_q == 8'h00);
    w_start    = rxc_q[0] && (rxd_q[7:0] == START_CHAR);
    w_term     = 1'b0;
    w_any_term = 1'b0;
    term_k     = '0;
    seen_ctl   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rxc_q[i]) begin
        if (rxd_q[8*i +: 8] == TERM_CHAR) begin
          w_any_term = 1'b1;
          if (!seen_ctl) begin
            w_term = 1'b1;
            term_k = 3'(i);
          end
        end
        seen_ctl = 1'b1;
      end
    end
  end

  assign len_full = {idx_q, 3'b000} + LW'(term_k);
  assign pop_ok   = rdy_pop_i && (cnt_q != '0);

  always_comb begin
    st_d       = st_q;
    slot_st_d  = slot_st_q;
    cur_d      = cur_q;
    idx_d      = idx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    push       = 1'b0;
    push_len   = len_full - FCS_BYTES;
    drop_inc   = 1'b0;
    alloc_req  = 1'b0;
    alloc_ok   = 1'b0;
    alloc_slot = '0;

    case (st_q)
      IDLE: begin
        if (w_start) alloc_req = 1'b1;
      end
      RECV: begin
        if (w_data) begin
          if (idx_q == IDX_FULL) begin
            slot_st_d[cur_q] = S_FREE;
            drop_inc         = 1'b1;
            st_d             = DROP;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cur_q, idx_q[IW-1:0]};
            wr_data_d = rxd_q;
            idx_d     = idx_q + 1'b1;
          end
        end else if (w_term) begin
          // A partial tail word on a full slot has nowhere to go.
          if ((term_k != 3'd0) && (idx_q == IDX_FULL)) begin
            slot_st_d[cur_q] = S_FREE;
            drop_inc         = 1'b1;
          end else begin
            if (term_k != 3'd0) begin
              wr_en_d   = 1'b1;
              wr_addr_d = {cur_q, idx_q[IW-1:0]};
              wr_data_d = rxd_q;
            end
            if (len_full < RUNT_MIN) begin
              slot_st_d[cur_q] = S_FREE;
              drop_inc         = 1'b1;
            end else begin
              slot_st_d[cur_q] = S_READY;
              push             = 1'b1;
            end
          end
          st_d = IDLE;
        end else begin
          slot_st_d[cur_q] = S_FREE;
          drop_inc         = 1'b1;
          if (w_start) alloc_req = 1'b1;
          else         st_d      = DROP;
        end
      end
      DROP: begin
        if (w_start)         alloc_req = 1'b1;
        else if (w_any_term) st_d      = IDLE;
      end
      default: st_d = IDLE;
    endcase

    // Allocation sees slots released this cycle as still HELD.
    if (alloc_req) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (slot_st_d[i] == S_FREE) begin
          alloc_ok   = 1'b1;
          alloc_slot = SW'(i);
        end
      end
      if (alloc_ok) begin
        slot_st_d[alloc_slot] = S_FILL;
        cur_d                 = alloc_slot;
        idx_d                 = '0;
        st_d                  = RECV;
      end else begin
        drop_inc = 1'b1;
        st_d     = DROP;
      end
    end

    if (pop_ok) slot_st_d[fifo_slot_q[rd_ptr_q]] = S_HELD;
    if (rel_i && (slot_st_q[rel_slot_i] == S_HELD)) slot_st_d[rel_slot_i] = S_FREE;
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rxd_q     <= '0;
      rxc_q     <= '0;
      st_q      <= IDLE;
      cur_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      irq_q     <= 1'b0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_st_q[i]   <= S_FREE;
        fifo_slot_q[i] <= '0;
        fifo_len_q[i]  <= '0;
      end
    end else begin
      rxd_q     <= xge_rxd_i;
      rxc_q     <= xge_rxc_i;
      st_q      <= st_d;
      cur_q     <= cur_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      irq_q     <= push;
      for (int i = 0; i < NUM_SLOTS; i++) slot_st_q[i] <= slot_st_d[i];
      if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (push) begin
        fifo_slot_q[wr_ptr_q] <= cur_q;
        fifo_len_q[wr_ptr_q]  <= push_len;
        wr_ptr_q              <= wr_ptr_q + SW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + SW'(1);
      cnt_q <= cnt_q + (SW+1)'(push) - (SW+1)'(pop_ok);
    end
  end

  assign buf_wr_en_o   = wr_en_q;
  assign buf_wr_addr_o = wr_addr_q;
  assign buf_wr_data_o = wr_data_q;
  assign rdy_valid_o   = (cnt_q != '0);
  assign rdy_slot_o    = fifo_slot_q[rd_ptr_q];
  assign rdy_len_o     = fifo_len_q[rd_ptr_q];
  assign irq_o         = irq_q;
  assign drop_cnt_o    = drop_q;

endmodule
